// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcode/funct codes,
// ALU control encodings, mux selects and the controller state encoding.
package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALU operation select
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU operand B select
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Controller states; the encoding is visible on the debug state port
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StIExec   = 4'd8,
        StIWb     = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StIllegal = 4'd12
    } state_e;

    // States whose exit to fetch retires an instruction
    function automatic logic is_completing(input state_e s);
        return s inside {StMemWb, StMemWr, StRWb, StIWb, StBranch, StJump};
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct to ALU control map; valid_o flags a supported funct.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       valid_o
);

    // Pure lookup; unsupported functs default to ADD with valid_o low
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        valid_o    = 1'b1;
        unique case (funct_i)
            FUNCT_ADD: alu_ctrl_o = ALU_ADD;
            FUNCT_SUB: alu_ctrl_o = ALU_SUB;
            FUNCT_AND: alu_ctrl_o = ALU_AND;
            FUNCT_OR:  alu_ctrl_o = ALU_OR;
            FUNCT_SLT: alu_ctrl_o = ALU_SLT;
            default:   valid_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/write-back, plus a retired-instruction counter for debug.
// Build option MIPS_CTRL_TRAP_EN: when defined, the illegal state is terminal
// until reset; otherwise it lasts one cycle and the instruction acts as a NOP.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [3:0]       dec_ctrl;
    logic             dec_valid;

    mips_alu_decode u_alu_decode (
        .funct_i    (funct),
        .alu_ctrl_o (dec_ctrl),
        .valid_o    (dec_valid)
    );

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    OP_LW, OP_SW:   state_d = StMemAddr;
                    OP_RTYPE:       state_d = StRExec;
                    OP_BEQ, OP_BNE: state_d = StBranch;
                    OP_ADDI:        state_d = StIExec;
                    OP_J:           state_d = StJump;
                    default:        state_d = StIllegal;
                endcase
            end
            StMemAddr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
            StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
            StRExec:   state_d = dec_valid ? StRWb : StIllegal;
            StRWb:     state_d = StFetch;
            StIExec:   state_d = StIWb;
            StIWb:     state_d = StFetch;
            StBranch:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StIllegal: begin
`ifdef MIPS_CTRL_TRAP_EN
                state_d = StIllegal;
`else
                state_d = StFetch;
`endif
            end
            default:   state_d = StFetch;
        endcase
    end

    // Count an instruction when a completing state hands back to fetch
    always_comb begin
        retired_d = retired_q;
        if (is_completing(state_q) && (state_d == StFetch)) begin
            retired_d = retired_q + CntOne;
        end
    end

    // State and counter registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Moore outputs; strobes are masked while reset is asserted
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_ctrl   = ALU_ADD;
        pc_src     = PC_SRC_ALU;
        unique case (state_q)
            StFetch: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRC_B_FOUR;
            end
            StDecode: alu_src_b = SRC_B_IMM_SH;
            StMemAddr, StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            StMemRd: mem_read = 1'b1;
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: mem_write = 1'b1;
            StRExec: begin
                alu_src_a = 1'b1;
                alu_ctrl  = dec_ctrl;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StIWb: reg_write = 1'b1;
            StBranch: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                // Only combinational strobe: taken-ness comes from the ALU compare
                pc_write  = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
            end
            StJump: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = (state_q == StIllegal);

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control with a 4-bit retired counter. Expected
// per-cycle outputs come from a small state-to-output reference table.
module tb_mips_mc_control;
    import mips_pkg::*;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = 6'h00;
    logic [5:0]    funct = 6'h20;
    logic          alu_zero = 1'b0;
    logic          mem_ready = 1'b1;
    logic          pc_write, ir_write, reg_write, mem_read, mem_write;
    logic          reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]    alu_src_b, pc_src;
    logic [3:0]    alu_ctrl, state;
    logic [CW-1:0] retired;
    logic          illegal;

    mips_mc_control #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .pc_src     (pc_src),
        .state      (state),
        .retired    (retired),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // sel/msk layout: [10] reg_dst [9] mem_to_reg [8] src_a [7:6] src_b [5:2] alu_ctrl [1:0] pc_src
    typedef struct packed {
        logic [3:0]    st;
        logic [4:0]    stb;  // {pc_write, ir_write, reg_write, mem_read, mem_write}
        logic [10:0]   sel;
        logic [10:0]   msk;
        logic          ill;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] exp_ret = '0;

    function automatic exp_t model(input logic [3:0] st);
        exp_t e;
        e.st  = st;
        e.stb = 5'b00000;
        e.sel = '0;
        e.msk = '0;
        e.ill = (st == StIllegal);
        e.ret = exp_ret;
        case (st)
            StFetch: begin
                e.stb = 5'b11000; e.sel = 11'b000_0100_1000; e.msk = 11'b001_1111_1111;
            end
            StDecode: begin
                e.sel = 11'b000_1100_1000; e.msk = 11'b001_1111_1100;
            end
            StMemAddr, StIExec: begin
                e.sel = 11'b001_1000_1000; e.msk = 11'b001_1111_1100;
            end
            StMemRd: e.stb = 5'b00010;
            StMemWb: begin
                e.stb = 5'b00100; e.sel = 11'b010_0000_0000; e.msk = 11'b110_0000_0000;
            end
            StMemWr: e.stb = 5'b00001;
            StRExec: begin
                e.sel[8:6] = 3'b100;
                e.msk      = 11'b001_1111_1100;
                case (funct)
                    6'h20:   e.sel[5:2] = 4'b0010;
                    6'h22:   e.sel[5:2] = 4'b0110;
                    6'h24:   e.sel[5:2] = 4'b0000;
                    6'h25:   e.sel[5:2] = 4'b0001;
                    6'h2A:   e.sel[5:2] = 4'b0111;
                    default: e.msk      = 11'b001_1100_0000;
                endcase
            end
            StRWb: begin
                e.stb = 5'b00100; e.sel = 11'b100_0000_0000; e.msk = 11'b110_0000_0000;
            end
            StIWb: begin
                e.stb = 5'b00100; e.msk = 11'b110_0000_0000;
            end
            StBranch: begin
                e.stb = {((opcode == 6'h05) ? ~alu_zero : alu_zero), 4'b0000};
                e.sel = 11'b001_0001_1001; e.msk = 11'b001_1111_1111;
            end
            StJump: begin
                e.stb = 5'b10000; e.sel = 11'b000_0000_0010; e.msk = 11'b000_0000_0011;
            end
            default: ;
        endcase
        if (rst) e.stb = 5'b00000;
        return e;
    endfunction

    // One cycle: queue the expectation, check mid-cycle, advance past the next edge
    task automatic cyc(input logic [3:0] st, input string tag);
        exp_t        e;
        logic [4:0]  o_stb;
        logic [10:0] o_sel;
        sb.push_back(model(st));
        #2;
        e     = sb.pop_front();
        o_stb = {pc_write, ir_write, reg_write, mem_read, mem_write};
        o_sel = {reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src};
        total++;
        assert (state === e.st) else begin
            bad++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, e.st);
        end
        total++;
        assert (o_stb === e.stb) else begin
            bad++;
            $error("FAIL %s strobes: got %b expected %b", tag, o_stb, e.stb);
        end
        total++;
        assert ((o_sel & e.msk) === (e.sel & e.msk)) else begin
            bad++;
            $error("FAIL %s selects: got %b expected %b mask %b", tag, o_sel, e.sel, e.msk);
        end
        total++;
        assert ({illegal, retired} === {e.ill, e.ret}) else begin
            bad++;
            $error("FAIL %s illegal/retired: got %b/%0d expected %b/%0d",
                   tag, illegal, retired, e.ill, e.ret);
        end
        @(posedge clk);
        #1;
    endtask

    logic [5:0] r_functs [5];

    initial begin
        r_functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        // Reset from power-up: two edges with rst high
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc(StFetch, "reset_hold");
        rst = 1'b0;

        // R-type ops
        for (int i = 0; i < 5; i++) begin
            opcode = 6'h00; funct = r_functs[i];
            cyc(StFetch, "r_fetch"); cyc(StDecode, "r_decode");
            cyc(StRExec, "r_exec");  cyc(StRWb, "r_wb");
            exp_ret++;
        end

        // addi
        opcode = 6'h08;
        cyc(StFetch, "addi_fetch"); cyc(StDecode, "addi_decode");
        cyc(StIExec, "addi_exec");  cyc(StIWb, "addi_wb");
        exp_ret++;

        // sw, no wait then one wait cycle
        opcode = 6'h2B;
        cyc(StFetch, "sw_fetch"); cyc(StDecode, "sw_decode");
        cyc(StMemAddr, "sw_addr"); cyc(StMemWr, "sw_wr");
        exp_ret++;
        cyc(StFetch, "sw2_fetch"); cyc(StDecode, "sw2_decode"); cyc(StMemAddr, "sw2_addr");
        mem_ready = 1'b0; cyc(StMemWr, "sw2_wait");
        mem_ready = 1'b1; cyc(StMemWr, "sw2_wr");
        exp_ret++;

        // lw with two wait cycles: 7 cycles, mem_read held 3
        opcode = 6'h23;
        cyc(StFetch, "lw_fetch"); cyc(StDecode, "lw_decode"); cyc(StMemAddr, "lw_addr");
        mem_ready = 1'b0;
        cyc(StMemRd, "lw_wait0"); cyc(StMemRd, "lw_wait1");
        mem_ready = 1'b1;
        cyc(StMemRd, "lw_rd"); cyc(StMemWb, "lw_wb");
        exp_ret++;

        // Branches, taken and not taken
        opcode = 6'h04; alu_zero = 1'b1;
        cyc(StFetch, "beq1_fetch"); cyc(StDecode, "beq1_decode"); cyc(StBranch, "beq1_br");
        exp_ret++;
        alu_zero = 1'b0;
        cyc(StFetch, "beq0_fetch"); cyc(StDecode, "beq0_decode"); cyc(StBranch, "beq0_br");
        exp_ret++;
        opcode = 6'h05; alu_zero = 1'b1;
        cyc(StFetch, "bne1_fetch"); cyc(StDecode, "bne1_decode"); cyc(StBranch, "bne1_br");
        exp_ret++;
        alu_zero = 1'b0;
        cyc(StFetch, "bne0_fetch"); cyc(StDecode, "bne0_decode"); cyc(StBranch, "bne0_br");
        exp_ret++;

        // Jump, with mem_ready low to show it is ignored outside memory states
        opcode = 6'h02; mem_ready = 1'b0;
        cyc(StFetch, "j_fetch"); cyc(StDecode, "j_decode"); cyc(StJump, "j_jump");
        mem_ready = 1'b1;
        exp_ret++;

        // Reset in the middle of a stalled lw
        opcode = 6'h23;
        cyc(StFetch, "rlw_fetch"); cyc(StDecode, "rlw_decode"); cyc(StMemAddr, "rlw_addr");
        mem_ready = 1'b0;
        cyc(StMemRd, "rlw_wait");
        rst = 1'b1;
        cyc(StMemRd, "rst_in_memrd");
        exp_ret = '0;
        cyc(StFetch, "rst_second");
        rst = 1'b0; mem_ready = 1'b1;

        // 16 jumps wrap the 4-bit counter back to 0
        opcode = 6'h02;
        for (int i = 0; i < 16; i++) begin
            cyc(StFetch, "wrap_fetch"); cyc(StDecode, "wrap_decode"); cyc(StJump, "wrap_jump");
            exp_ret++;
        end

`ifdef MIPS_CTRL_TRAP_EN
        opcode = 6'h3F;
        cyc(StFetch, "ill_fetch"); cyc(StDecode, "ill_decode");
        for (int i = 0; i < 10; i++) cyc(StIllegal, "ill_trap");
        rst = 1'b1;
        cyc(StIllegal, "ill_rst");
        exp_ret = '0;
        rst = 1'b0;
        opcode = 6'h02;
        cyc(StFetch, "ill_recover");
`else
        opcode = 6'h3F;
        cyc(StFetch, "ill_fetch"); cyc(StDecode, "ill_decode");
        cyc(StIllegal, "ill_pulse"); cyc(StFetch, "ill_nop");
        // Unsupported funct traps from R_EXEC
        opcode = 6'h00; funct = 6'h3F;
        cyc(StDecode, "badf_decode"); cyc(StRExec, "badf_exec");
        cyc(StIllegal, "badf_pulse"); cyc(StFetch, "badf_nop");
        funct = 6'h20;
        cyc(StDecode, "after_decode"); cyc(StRExec, "after_exec"); cyc(StRWb, "after_wb");
        exp_ret++;
        cyc(StFetch, "after_fetch");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle control unit for the MIPS datapath. Sequences the register file, instruction memory, data memory, ALU and PC through the fetch, decode, execute, memory and write-back steps. It is a Moore FSM driving the datapath's select and write-strobe signals from the IR opcode/funct fields and the ALU zero flag. It also reports the FSM state and a retired-instruction count for the TestPort debug path.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  single system clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  data-memory ready; tie to 1 for single-cycle memory
- pc_write  out  1  PC load strobe
- ir_write  out  1  IR load strobe
- reg_write  out  1  register-file write strobe
- mem_read  out  1  data-memory read strobe
- mem_write  out  1  data-memory write strobe
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sext imm, 11 = sext imm<<2
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current FSM state encoding
- retired  out  CNT_W  instructions completed
- illegal  out  1  unsupported opcode/funct was decoded

## Operation
Supported instructions:
- R-type (opcode 0x00), funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt
- lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, j 0x02

States and their outputs (any output not listed is 0 or don't-care):
- FETCH: ir_write=1, pc_write=1, src_a=0, src_b=01, ADD, pc_src=00. Next state is DECODE.
- DECODE: src_a=0, src_b=11, ADD (branch target into ALUOut). Next state is chosen by opcode:
  - lw/sw → MEM_ADDR
  - R-type → R_EXEC
  - beq/bne → BRANCH
  - addi → I_EXEC
  - j → JUMP
  - unsupported → ILLEGAL
- MEM_ADDR: src_a=1, src_b=10, ADD. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1. Holds while mem_ready=0, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state is FETCH.
- MEM_WR: mem_write=1. Holds while mem_ready=0, then goes to FETCH.
- R_EXEC: src_a=1, src_b=00, alu_ctrl decoded from funct. Next state is R_WB; an unsupported funct goes to ILLEGAL instead.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state is FETCH.
- I_EXEC: src_a=1, src_b=10, ADD. Next state is I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
- BRANCH: src_a=1, src_b=00, SUB, pc_src=01. pc_write is the only combinational term: alu_zero for beq, !alu_zero for bne. Next state is FETCH.
- JUMP: pc_src=10, pc_write=1. Next state is FETCH.
- ILLEGAL: illegal=1. Behaviour depends on the configuration macro.

Retired-instruction counter:
- retired increments by 1 on every transition into FETCH from a completing state (MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP).
- It wraps modulo 2^CNT_W.
- ILLEGAL does not count.

## Timing
- Reset:
  - While rst=1, every strobe (pc_write, ir_write, reg_write, mem_read, mem_write) is forced to 0.
  - On the edge with rst=1: state←FETCH, retired←0, illegal←0.
  - First FETCH strobes appear in the cycle after rst deasserts.
  - rst mid-instruction abandons it; no partial write strobe is issued.
- Latency in cycles, with mem_ready always 1:
  - j, beq, bne: 3
  - R-type, addi, sw: 4
  - lw: 5
- Each cycle mem_ready=0 in MEM_RD/MEM_WR adds one cycle. Strobes stay asserted and all other outputs stay stable while waiting.
- Strobes are asserted for exactly one cycle per state visit, except while waiting on mem_ready.
- mem_ready is ignored in all states other than MEM_RD/MEM_WR.

## Configuration
- MIPS_CTRL_TRAP_EN defined:
  - ILLEGAL is terminal: it holds with illegal=1 and no strobes until rst.
- MIPS_CTRL_TRAP_EN not defined:
  - ILLEGAL lasts one cycle with illegal=1, then goes to FETCH, so the instruction executes as a NOP (PC was already incremented).
  - illegal is a one-cycle pulse; retired is not incremented.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants
  - alu_ctrl constants
  - alu_src_b and pc_src select constants
  - the state enum typedef (4-bit)
- One sub-module, mips_alu_decode: a combinational funct → alu_ctrl map with a valid flag, reused by the datapath ALU.

## Test plan
- Reset: hold rst for 2 cycles in the middle of MEM_RD → strobes stay 0, then state=FETCH, retired=0, first FETCH has ir_write=pc_write=1.
- add (0x00/0x20) → 4 cycles: FETCH, DECODE, R_EXEC with alu_ctrl=0010, R_WB with reg_write=1 and reg_dst=1; retired=1.
- lw with mem_ready low for 2 cycles in MEM_RD → 7 cycles total, mem_read held for 3 cycles, MEM_WB has mem_to_reg=1.
- beq with alu_zero=1 → pc_write=1, pc_src=01 in BRANCH. bne with alu_zero=1 → pc_write=0. Each takes 3 cycles.
- opcode 0x3F:
  - with MIPS_CTRL_TRAP_EN → illegal stays 1 and no strobes for 10 cycles.
  - without it → 1-cycle illegal pulse, then FETCH, retired unchanged.
- Counter wrap with CNT_W=4: 16 j instructions → retired returns to 0.
